// File: rtl/sifive_amba_prot_decode_slice.sv
// AXI4 address-channel slice: decodes AxPROT/AxCACHE into AMBA flags,
// flags non-secure hits on a secure window, and counts delivered denials.
module sifive_amba_prot_decode_slice #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [ID_W-1:0]   s_id,
   input  logic [2:0]        s_prot,
   input  logic [3:0]        s_cache,
   input  logic [ADDR_W-1:0] sec_base,
   input  logic [ADDR_W-1:0] sec_limit,
   input  logic              cnt_clear,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [ID_W-1:0]   m_id,
   output logic              m_fetch,
   output logic              m_secure,
   output logic              m_privileged,
   output logic              m_writealloc,
   output logic              m_readalloc,
   output logic              m_modifiable,
   output logic              m_bufferable,
   output logic              m_deny,
   output logic [15:0]       deny_count
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
      logic              fetch;
      logic              secure;
      logic              privileged;
      logic              writealloc;
      logic              readalloc;
      logic              modifiable;
      logic              bufferable;
      logic              deny;
   } beat_t;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]  state_q, state_d;
   beat_t       out_q, out_d;
   beat_t       skid_q, skid_d;
   logic [15:0] cnt_q, cnt_d;
   beat_t       in_beat;
   logic        accept;

   always_comb begin
      in_beat            = '0;
      in_beat.addr       = s_addr;
      in_beat.id         = s_id;
      in_beat.fetch      = s_prot[2];
      in_beat.secure     = ~s_prot[1];
      in_beat.privileged = s_prot[0];
      in_beat.bufferable = s_cache[0];
      in_beat.modifiable = s_cache[1];
      in_beat.readalloc  = s_cache[2];
      in_beat.writealloc = s_cache[3];
      in_beat.deny       = s_prot[1] && (sec_base <= s_addr)
                           && (s_addr <= sec_limit);
   end

   // s_ready depends only on the state register, never on m_ready
   assign s_ready = reset_n && (state_q != ST_FULL);
   assign m_valid = (state_q != ST_EMPTY);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_d   = in_beat;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && m_ready) begin
               out_d = in_beat;
            end else if (accept) begin
               skid_d  = in_beat;
               state_d = ST_FULL;
            end else if (m_ready) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (m_ready) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (cnt_clear) begin
         cnt_d = '0;
      end else if (m_valid && m_ready && out_q.deny
                   && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_addr       = out_q.addr;
   assign m_id         = out_q.id;
   assign m_fetch      = out_q.fetch;
   assign m_secure     = out_q.secure;
   assign m_privileged = out_q.privileged;
   assign m_writealloc = out_q.writealloc;
   assign m_readalloc  = out_q.readalloc;
   assign m_modifiable = out_q.modifiable;
   assign m_bufferable = out_q.bufferable;
   assign m_deny       = out_q.deny;
   assign deny_count   = cnt_q;

endmodule

// File: tb/tb_sifive_amba_prot_decode_slice.sv
// Directed bench for sifive_amba_prot_decode_slice: decode table,
// stream/stall scoreboard, window edges, counter saturation and reset.
module tb_sifive_amba_prot_decode_slice;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        s_valid, s_ready;
   logic [31:0] s_addr;
   logic [3:0]  s_id;
   logic [2:0]  s_prot;
   logic [3:0]  s_cache;
   logic [31:0] sec_base, sec_limit;
   logic        cnt_clear;
   logic        m_valid, m_ready;
   logic [31:0] m_addr;
   logic [3:0]  m_id;
   logic        m_fetch, m_secure, m_privileged, m_writealloc;
   logic        m_readalloc, m_modifiable, m_bufferable, m_deny;
   logic [15:0] deny_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   sifive_amba_prot_decode_slice #(.ADDR_W(32), .ID_W(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_addr(s_addr), .s_id(s_id),
      .s_prot(s_prot), .s_cache(s_cache),
      .sec_base(sec_base), .sec_limit(sec_limit),
      .cnt_clear(cnt_clear),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_addr(m_addr), .m_id(m_id),
      .m_fetch(m_fetch), .m_secure(m_secure),
      .m_privileged(m_privileged), .m_writealloc(m_writealloc),
      .m_readalloc(m_readalloc), .m_modifiable(m_modifiable),
      .m_bufferable(m_bufferable), .m_deny(m_deny),
      .deny_count(deny_count)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  prot;
      logic [3:0]  cache;
      logic [31:0] base;
      logic [31:0] limit;
      logic [6:0]  flags;
      logic        deny;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_stream(input int n, input logic [15:0] stall,
                             input logic [15:0] exp_rdy);
      logic [3:0] q[$];
      int next_id = 0;
      int got = 0;
      int c = 0;
      logic acc, del;
      while (got < n && c < 60) begin
         s_valid = (next_id < n);
         s_id    = 4'(next_id);
         s_addr  = 32'h100 + 32'(next_id);
         m_ready = (c < 16) ? ~stall[c] : 1'b1;
         @(negedge clock);
         if (c < 16) check($sformatf("s_ready c%0d", c), 32'(s_ready),
                           32'(exp_rdy[c]));
         acc = s_valid && s_ready;
         del = m_valid && m_ready;
         if (del) begin
            if (q.size() == 0) check("spurious beat", 32'(m_id), 32'hFFFF);
            else check($sformatf("stream id %0d", got), 32'(m_id),
                       32'(q.pop_front()));
            got++;
         end
         if (acc) begin
            q.push_back(s_id);
            next_id++;
         end
         c++;
         tick();
      end
      s_valid = 1'b0;
      check("stream all delivered", 32'(got), 32'(n));
   endtask

   initial begin
      // flags order: fetch secure priv walloc ralloc modif buff
      vecs[0] = '{32'h1000,     3'b010, 4'b1011, 32'h8000, 32'h8FFF,
                  7'b0001011, 1'b0};
      vecs[1] = '{32'h8000,     3'b010, 4'b0000, 32'h8000, 32'h8FFF,
                  7'b0000000, 1'b1};
      vecs[2] = '{32'h8FFF,     3'b011, 4'b0100, 32'h8000, 32'h8FFF,
                  7'b0010100, 1'b1};
      vecs[3] = '{32'h9000,     3'b110, 4'b1000, 32'h8000, 32'h8FFF,
                  7'b1001000, 1'b0};
      vecs[4] = '{32'h8400,     3'b000, 4'b0010, 32'h8000, 32'h8FFF,
                  7'b0100010, 1'b0};
      vecs[5] = '{32'h8800,     3'b010, 4'b0001, 32'h9000, 32'h8000,
                  7'b0000001, 1'b0};
      vecs[6] = '{32'hFFFFFFFF, 3'b111, 4'b1111, 32'h0, 32'hFFFFFFFF,
                  7'b1011111, 1'b1};

      reset_n = 1'b0; s_valid = 1'b0; s_addr = '0; s_id = '0;
      s_prot = '0; s_cache = '0; sec_base = 32'h8000;
      sec_limit = 32'h8FFF; cnt_clear = 1'b0; m_ready = 1'b1;
      repeat (3) tick();
      check("reset m_valid", 32'(m_valid), 0);
      check("reset s_ready", 32'(s_ready), 0);
      check("reset deny_count", 32'(deny_count), 0);
      check("reset m_addr", m_addr, 0);
      reset_n = 1'b1;
      #1;
      check("release s_ready", 32'(s_ready), 1);

      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_addr = vecs[i].addr; s_id = 4'(i);
         s_prot = vecs[i].prot; s_cache = vecs[i].cache;
         sec_base = vecs[i].base; sec_limit = vecs[i].limit;
         tick();
         check($sformatf("vec%0d m_valid", i), 32'(m_valid), 1);
         check($sformatf("vec%0d addr", i), m_addr, vecs[i].addr);
         check($sformatf("vec%0d id", i), 32'(m_id), i);
         check($sformatf("vec%0d flags", i),
               32'({m_fetch, m_secure, m_privileged, m_writealloc,
                    m_readalloc, m_modifiable, m_bufferable}),
               32'(vecs[i].flags));
         check($sformatf("vec%0d deny", i), 32'(m_deny),
               32'(vecs[i].deny));
      end
      s_valid = 1'b0;
      tick();
      check("vec drain m_valid", 32'(m_valid), 0);
      check("vec deny_count", 32'(deny_count), 3);

      sec_base = 32'h8000; sec_limit = 32'h8FFF; s_prot = 3'b000;
      run_stream(8, 16'h0000, 16'hFFFF);
      run_stream(10, 16'b0000_0000_0011_1000, 16'b1111_1111_1000_1111);
      tick();
      check("post stream m_valid", 32'(m_valid), 0);
      check("post stream deny_count", 32'(deny_count), 3);

      // drive denied beats until the counter saturates
      s_valid = 1'b1; s_addr = 32'h8000; s_prot = 3'b010; m_ready = 1'b1;
      begin
         int c = 0;
         while (deny_count != 16'hFFFF && c < 70000) begin
            tick();
            c++;
         end
      end
      check("saturate reached", 32'(deny_count), 32'hFFFF);
      repeat (3) tick();
      check("saturate hold", 32'(deny_count), 32'hFFFF);
      check("sat m_deny", 32'(m_deny), 1);
      cnt_clear = 1'b1;
      tick();
      check("clear wins", 32'(deny_count), 0);
      cnt_clear = 1'b0;
      tick();
      check("count resumes", 32'(deny_count), 1);

      m_ready = 1'b0;
      repeat (2) tick();
      check("full s_ready", 32'(s_ready), 0);
      check("full m_valid", 32'(m_valid), 1);
      reset_n = 1'b0;
      tick();
      check("mid reset m_valid", 32'(m_valid), 0);
      check("mid reset deny_count", 32'(deny_count), 0);
      check("mid reset m_deny", 32'(m_deny), 0);
      check("mid reset s_ready", 32'(s_ready), 0);
      s_valid = 1'b0; m_ready = 1'b1; reset_n = 1'b1;
      #1;
      check("mid release s_ready", 32'(s_ready), 1);
      tick();
      check("no stale beat", 32'(m_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sifive_amba_prot_decode_slice.md
# sifive_amba_prot_decode_slice

AXI4 address-channel register slice that decodes raw AxPROT/AxCACHE fields into the seven discrete AMBA protection flags (fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable) consumed by downstream SiFive fabric logic. It also flags non-secure accesses that hit a configured secure address window and counts such denials. It sits on the inbound side of an AXI4 slave port, between the external master and the internal address decoder, and provides full-throughput buffering with one cycle of latency.

## Interface
- ADDR_W, 32, address width
- ID_W, 4, transaction ID width
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  upstream address beat valid
- s_ready  out  1  slice can accept a beat
- s_addr  in  ADDR_W  beat address
- s_id  in  ID_W  beat ID
- s_prot  in  3  AxPROT: [0] privileged, [1] non-secure, [2] instruction
- s_cache  in  4  AxCACHE: [0] bufferable, [1] modifiable, [2] readalloc, [3] writealloc
- sec_base, sec_limit  in  ADDR_W each  inclusive secure window; empty when sec_base > sec_limit
- cnt_clear  in  1  clears deny counter
- m_valid  out  1  downstream beat valid
- m_ready  in  1  downstream accepts
- m_addr, m_id  out  ADDR_W, ID_W  registered payload
- m_fetch, m_secure, m_privileged, m_writealloc, m_readalloc, m_modifiable, m_bufferable  out  1 each  decoded flags
- m_deny  out  1  beat is non-secure and inside secure window
- deny_count  out  16  saturating count of denied beats delivered

## Operation
- Decode, computed on input side and stored with the payload: fetch=s_prot[2], secure=~s_prot[1], privileged=s_prot[0], bufferable=s_cache[0], modifiable=s_cache[1], readalloc=s_cache[2], writealloc=s_cache[3].
- deny = ~secure && (sec_base <= s_addr) && (s_addr <= sec_limit), unsigned compare; sec_base/sec_limit sampled at the cycle the beat is accepted.
- Storage: output register plus one skid register. States EMPTY, ONE, FULL.
  - EMPTY: s_valid -> load output reg, go ONE.
  - ONE: s_valid&&m_ready -> reload output reg, stay ONE; s_valid&&!m_ready -> load skid, go FULL; !s_valid&&m_ready -> go EMPTY.
  - FULL: m_ready -> move skid to output reg, go ONE; else hold.
- m_valid = (state != EMPTY). s_ready = reset_n && (state != FULL), derived from state register only (no combinational path from m_ready).
- Beat order strictly preserved; no beat dropped or duplicated; payload stable while m_valid && !m_ready.
- deny_count: +1 on each cycle with m_valid&&m_ready&&m_deny; saturates at 0xFFFF. cnt_clear sets it to 0 and wins over a simultaneous increment.
- Denied beats are still forwarded; enforcement is downstream's job.

## Timing
- Reset (reset_n low at a clock edge): state=EMPTY, m_valid=0, all payload/flag outputs 0, m_deny=0, deny_count=0. s_ready=0 while reset_n low, 1 on the first cycle after release.
- Reset mid-operation discards both stored beats with no output handshake.
- Latency: beat accepted at edge N appears on m_* with m_valid=1 after edge N (one cycle).
- Throughput: one beat per cycle sustained while m_ready=1.
- m_ready low for k cycles with continuous s_valid: one extra beat absorbed, s_ready drops the cycle after FULL is entered, recovers the cycle after the first downstream accept.
- m_valid ignored by no rule: slice may present beats while m_ready=0; upstream must hold s_* stable while s_valid&&!s_ready (AXI rule, not checked).

## Test plan
- Reset release, s_valid=1, s_addr=0x1000, s_prot=3'b010, s_cache=4'b1011, m_ready=1 -> next cycle m_valid=1, m_secure=0, m_privileged=0, m_fetch=0, m_bufferable=1, m_modifiable=1, m_readalloc=0, m_writealloc=1.
- Streaming 8 beats IDs 0..7, m_ready=1 -> 8 consecutive output beats, IDs in order, s_ready never low.
- m_ready=0 for 3 cycles during stream -> two beats held, s_ready=0 from second stalled cycle, IDs resume in order with no loss when m_ready=1.
- sec_base=0x8000, sec_limit=0x8FFF; beats at 0x8000 prot[1]=1, 0x8FFF prot[1]=1, 0x9000 prot[1]=1, 0x8400 prot[1]=0 -> m_deny 1,1,0,0; deny_count=2.
- sec_base=0x9000 > sec_limit=0x8000, non-secure beat at 0x8800 -> m_deny=0.
- Preload deny_count to 0xFFFF with denied beats, send one more -> stays 0xFFFF; assert cnt_clear with a denied beat delivered same cycle -> 0; reset_n low while FULL -> m_valid=0, deny_count=0 next cycle.
